// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Matrix keypad scanner: drives one column low at a time, samples the
// synchronised active-low rows, debounces whole-frame snapshots and reports
// press / release events plus a held level. Multi-key frames are rejected.
//
// Optional build macro: KEYPAD_HEX_MAP_EN
//   defined   -> key_code carries the 4x4 PMOD hex legend (4x4 keypads only)
//   undefined -> key_code = r*COLS + c
module keypad_scan_ctrl #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int COL_CYC         = 100000,
    parameter int SETTLE_CYC      = 8,
    parameter int DEBOUNCE_FRAMES = 4,
    localparam int KW             = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            key_release,
    output logic            multi_key
);

    localparam int SW = $clog2(COL_CYC);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [SW-1:0] SLOT_PRE  = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(COL_CYC - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_FRAMES);

    // Elaboration-time parameter sanity
    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8) begin : g_bad_dims
        $error("keypad_scan_ctrl: ROWS and COLS must be within 2..8");
    end
    if (SETTLE_CYC < 3 || COL_CYC <= SETTLE_CYC) begin : g_bad_timing
        $error("keypad_scan_ctrl: need SETTLE_CYC >= 3 and COL_CYC > SETTLE_CYC");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_bad_deb
        $error("keypad_scan_ctrl: DEBOUNCE_FRAMES must be >= 1");
    end
`ifdef KEYPAD_HEX_MAP_EN
    if (ROWS != 4 || COLS != 4) begin : g_bad_hex
        $error("keypad_scan_ctrl: hex legend mapping needs a 4x4 keypad");
    end
`endif

    // IDLE only exists between reset and the first scan slot, so col stays
    // all-ones while rst_n is low and column 0 starts on the first clk after.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_HOLD,
        S_EVAL
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [SW-1:0]              r_slot;
    logic [CW-1:0]              r_col_idx;
    logic [ROWS-1:0]            r_row_s1;
    logic [ROWS-1:0]            r_row_s2;
    logic [COLS-1:0][ROWS-1:0]  r_snap;      // 1 = key pressed
    logic                       r_cand_none;
    logic [KW-1:0]              r_cand_code;
    logic [DW-1:0]              r_deb_cnt;
    logic [KW-1:0]              r_code;
    logic                       r_valid;
    logic                       r_held;
    logic                       r_release;
    logic                       r_multi;

    logic                       w_slot_last;
    logic                       w_col_last;
    logic                       w_scan;
    logic                       w_sample;
    logic                       w_eval;
    logic [COLS-1:0]            w_col;
    logic                       w_seen;
    logic                       w_many;
    logic [KW-1:0]              w_idx;
    logic [KW-1:0]              w_fcode;
    logic                       w_fnone;
    logic                       w_same;
    logic [DW-1:0]              w_cnt_nxt;
    logic                       w_accept;

    assign w_slot_last = (r_slot == SLOT_LAST);
    assign w_col_last  = (r_col_idx == COL_LAST);

    // Two-flop synchroniser for the asynchronous rows (idle = all high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= '1;
            r_row_s2 <= '1;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Scan FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Scan FSM: next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_DRIVE;
            S_DRIVE:  if (r_slot == SLOT_PRE) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (w_slot_last) w_next = w_col_last ? S_EVAL : S_DRIVE;
                else             w_next = S_HOLD;
            end
            S_HOLD:   if (w_slot_last) w_next = w_col_last ? S_EVAL : S_DRIVE;
            S_EVAL:   w_next = S_DRIVE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Scan FSM: outputs (column drive and datapath strobes)
    always_comb begin
        w_scan   = (r_state == S_DRIVE) || (r_state == S_SAMPLE) || (r_state == S_HOLD);
        w_sample = (r_state == S_SAMPLE);
        w_eval   = (r_state == S_EVAL);
        w_col    = '1;
        if (w_scan) w_col[r_col_idx] = 1'b0;
    end

    // Slot cycle counter and column index; both park at zero outside a slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_col_idx <= '0;
        end else if (w_scan) begin
            if (w_slot_last) begin
                r_slot    <= '0;
                r_col_idx <= w_col_last ? '0 : r_col_idx + CW'(1);
            end else begin
                r_slot    <= r_slot + SW'(1);
            end
        end else begin
            r_slot    <= '0;
            r_col_idx <= '0;
        end
    end

    // Capture the settled rows of the driven column into the snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_snap            <= '0;
        else if (w_sample) r_snap[r_col_idx] <= ~r_row_s2;
    end

    // Snapshot classification: none / exactly one (with its index) / several
    always_comb begin
        w_seen = 1'b0;
        w_many = 1'b0;
        w_idx  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_snap[c][r]) begin
                    if (w_seen) w_many = 1'b1;
                    w_seen = 1'b1;
                    w_idx  = KW'(r*COLS + c);
                end
            end
        end
    end

`ifdef KEYPAD_HEX_MAP_EN
    // PMOD legend, entry 15 first: r3 = 0 F E D, r2 = 7 8 9 C, ...
    localparam logic [15:0][3:0] HEX_LUT = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };
    assign w_fcode = HEX_LUT[w_idx];
`else
    assign w_fcode = w_idx;
`endif

    // Debounce decision for a single-or-none frame; the candidate code is
    // ignored while the candidate is NONE
    always_comb begin
        w_fnone   = !w_seen;
        w_same    = (w_fnone == r_cand_none) && (w_fnone || (w_fcode == r_cand_code));
        w_cnt_nxt = DW'(1);
        if (w_same) w_cnt_nxt = (r_deb_cnt == DEB_MAX) ? DEB_MAX : r_deb_cnt + DW'(1);
        w_accept  = (w_cnt_nxt == DEB_MAX);
    end

    // Frame evaluation: candidate/counter update and registered key events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_none <= 1'b1;
            r_cand_code <= '0;
            r_deb_cnt   <= '0;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_held      <= 1'b0;
            r_release   <= 1'b0;
            r_multi     <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_release <= 1'b0;
            if (w_eval) begin
                if (w_many) begin
                    // Ambiguous frame: restart debouncing, keep everything else
                    r_multi   <= 1'b1;
                    r_deb_cnt <= '0;
                end else begin
                    r_multi     <= 1'b0;
                    r_deb_cnt   <= w_cnt_nxt;
                    r_cand_none <= w_fnone;
                    r_cand_code <= w_fcode;
                    if (w_accept) begin
                        if (!w_fnone && (!r_held || (w_fcode != r_code))) begin
                            r_code  <= w_fcode;
                            r_valid <= 1'b1;
                            r_held  <= 1'b1;
                        end else if (w_fnone && r_held) begin
                            r_held    <= 1'b0;
                            r_release <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign col         = w_col;
    assign key_code    = r_code;
    assign key_valid   = r_valid;
    assign key_held    = r_held;
    assign key_release = r_release;
    assign multi_key   = r_multi;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 PMOD decoder.
- Drives one column low at a time, samples active-low rows, and assembles a full-frame snapshot.
- Debounces across frames, rejects multi-key frames, and reports press/release events with a held level.
- Sits between the PMOD keypad pins and the display/command logic.

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- COL_CYC, 100000, clk cycles per column slot (1 ms at 100 MHz); must be > SETTLE_CYC
- SETTLE_CYC, 8, slot cycle at which synchronised rows are sampled; >= 3
- DEBOUNCE_FRAMES, 4, consecutive identical frames required to accept a press or a release; >= 1
- KW, $clog2(ROWS*COLS), key_code width (derived localparam, not overridable)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  keypad rows, active-low, asynchronous to clk
- col  out  COLS  column drive, one-cold while scanning
- key_code  out  KW  code of the accepted key
- key_valid  out  1  one-cycle pulse when a new key is accepted
- key_held  out  1  high while an accepted key remains debounced-pressed
- key_release  out  1  one-cycle pulse when the held key is debounced-released
- multi_key  out  1  high after any frame with more than one key pressed

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: col = all ones, key_code = 0; key_valid, key_held, key_release, multi_key = 0.
  - Internal: slot counter, column index, debounce counter, candidate and snapshot cleared.
  - Reset mid-frame aborts the frame. The first slot (column 0) starts on the first clk after rst_n goes high.
- Input sync: row passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- Scan FSM states:
  - DRIVE: slot cycles 0..SETTLE_CYC-1; col bit c low, all others high.
  - SAMPLE: slot cycle SETTLE_CYC; synchronised row captured into snapshot column c.
  - HOLD: remaining cycles to COL_CYC-1.
  - At the end of HOLD, c increments; after c = COLS-1 the FSM goes to EVAL, then back to DRIVE with c = 0.
  - EVAL costs exactly one cycle, so frame length = COLS*COL_CYC + 1 cycles.
- Key index:
  - Row bit r low with column c driven means key (r,c).
  - code = r*COLS + c.
- EVAL classification (pressed-key count n in the snapshot):
  - n = 0: frame value NONE.
  - n = 1: frame value is that key's code.
  - n >= 2: multi_key set to 1, debounce counter cleared, no other output change. multi_key clears at the next EVAL with n <= 1.
- Debounce:
  - If the frame value equals the stored candidate, the counter increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise the candidate is replaced and the counter is set to 1.
  - Acceptance happens when the counter reaches DEBOUNCE_FRAMES at this EVAL.
- On acceptance (outputs registered; they change the cycle after EVAL):
  - candidate = key K, and either key_held = 0 or K differs from key_code: key_code = K, key_valid pulses, key_held = 1.
  - K equals the current key_code while held: no event.
  - candidate = NONE and key_held = 1: key_held = 0, key_release pulses; key_code keeps its last value.
  - Direct change from held key A to stable key B: key_valid pulse with B; no key_release pulse.
- Each of key_valid and key_release pulses at most once per frame, never both in the same cycle.
- Latency: a press clean from frame F is accepted at EVAL of frame F+DEBOUNCE_FRAMES-1.

Optional Feature:
- Macro: KEYPAD_HEX_MAP_EN.
- Defined:
  - key_code carries the hex legend instead of the linear index; valid only when ROWS = COLS = 4 (elaboration error otherwise).
  - Legend (r,c): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D.
  - Comparison for "same key" uses the mapped code.
- Undefined: linear index code = r*COLS + c.

Test Plan (ROWS = COLS = 4, COL_CYC = 16, SETTLE_CYC = 8, DEBOUNCE_FRAMES = 3; frame = 65 cycles):
- Idle, no key -> col cycles 1110, 1101, 1011, 0111, 16 clk each, plus 1 EVAL cycle; no pulses; multi_key = 0.
- Hold (r1,c2) from before frame 0 -> key_valid single pulse after EVAL of frame 2; key_code = 6; key_held = 1. With KEYPAD_HEX_MAP_EN, (r3,c1) -> key_code = 4'hF.
- Key (r0,c0) bouncing, present on alternate frames for 10 frames -> no key_valid; key_held stays 0.
- Held key 6, then release for 3 frames -> key_release single pulse after EVAL of the 3rd empty frame; key_held = 0; key_code stays 6.
- (r0,c0) and (r2,c3) held together -> multi_key = 1 from the first EVAL, no key_valid. Release (r2,c3) -> multi_key = 0 at the next EVAL, key_valid (code 0) after 3 frames.
- rst_n low mid-slot of column 2 while key_held = 1 -> col = 1111 and all outputs 0 immediately (asynchronous); after release, scan restarts at column 0.
